// File: rtl/scan_decoder.sv
// scan_decoder: N-to-2**N one-hot decoder with a direct (handshaked select)
// mode and an auto-scan mode that dwells DWELL cycles on each index.
module scan_decoder #(
    parameter int unsigned N     = 2,
    parameter int unsigned DWELL = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic [N-1:0]     sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [2**N-1:0]  dout,
    output logic             out_valid,
    output logic [N-1:0]     idx,
    output logic             wrap
);

    localparam int unsigned W  = 2 ** N;
    localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;

    // Select is only accepted while already settled in DIRECT and staying there
    assign in_ready = (state == DIRECT) && en && !mode;

    // Mode FSM with registered decoder outputs; en/mode re-evaluated every edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            dout      <= '0;
            out_valid <= 1'b0;
            idx       <= '0;
            cnt       <= '0;
            wrap      <= 1'b0;
        end else if (!en) begin
            state     <= IDLE;
            dout      <= '0;
            out_valid <= 1'b0;
            idx       <= '0;
            cnt       <= '0;
            wrap      <= 1'b0;
        end else if (!mode) begin
            wrap <= 1'b0;
            cnt  <= '0;
            if (state != DIRECT) begin
                // Entry edge clears the output; no handshake can complete here
                state     <= DIRECT;
                dout      <= '0;
                out_valid <= 1'b0;
                idx       <= '0;
            end else if (in_valid) begin
                dout      <= W'(1) << sel;
                idx       <= sel;
                out_valid <= 1'b1;
            end
        end else begin
            if (state != SCAN) begin
                // Scan always restarts at index 0 with a fresh dwell period
                state     <= SCAN;
                dout      <= W'(1);
                out_valid <= 1'b1;
                idx       <= '0;
                cnt       <= '0;
                wrap      <= 1'b0;
            end else if (cnt == CW'(DWELL - 1)) begin
                cnt  <= '0;
                idx  <= idx + N'(1);
                dout <= {dout[W-2:0], dout[W-1]};
                wrap <= (idx == N'(W - 1));
            end else begin
                cnt  <= cnt + CW'(1);
                wrap <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_scan_decoder.sv
// Self-checking bench for scan_decoder: table of direct-mode vectors plus
// hand-written scan, reset and DWELL=1 sequences.
module tb_scan_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       en, mode, in_valid, in_ready;
    logic [1:0] sel, idx;
    logic [3:0] dout;
    logic       out_valid, wrap;

    logic       en2, mode2, in_valid2, in_ready2;
    logic [2:0] sel2, idx2;
    logic [7:0] dout2;
    logic       out_valid2, wrap2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    scan_decoder #(.N(2), .DWELL(4)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel),
        .in_valid(in_valid), .in_ready(in_ready), .dout(dout),
        .out_valid(out_valid), .idx(idx), .wrap(wrap)
    );

    scan_decoder #(.N(3), .DWELL(1)) dut2 (
        .clk(clk), .rst(rst), .en(en2), .mode(mode2), .sel(sel2),
        .in_valid(in_valid2), .in_ready(in_ready2), .dout(dout2),
        .out_valid(out_valid2), .idx(idx2), .wrap(wrap2)
    );

    typedef struct {
        logic       en;
        logic       mode;
        logic [1:0] sel;
        logic       iv;
        logic       rdy;
        logic [3:0] dout;
        logic [1:0] idx;
        logic       ov;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input int unsigned e_dout, input int unsigned e_idx,
                           input int unsigned e_ov, input int unsigned e_wrap);
        chk({tag, ".dout"}, 32'(dout), e_dout);
        chk({tag, ".idx"}, 32'(idx), e_idx);
        chk({tag, ".out_valid"}, 32'(out_valid), e_ov);
        chk({tag, ".wrap"}, 32'(wrap), e_wrap);
    endtask

    initial begin
        int wraps;
        int unsigned e_idx;

        //            en    mode  sel   iv    rdy   dout     idx   ov
        vecs[0]  = '{1'b1, 1'b0, 2'd3, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0}; // IDLE->DIRECT, no capture
        vecs[1]  = '{1'b1, 1'b0, 2'd3, 1'b1, 1'b1, 4'b1000, 2'd3, 1'b1}; // capture sel=3
        vecs[2]  = '{1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 4'b1000, 2'd3, 1'b1}; // hold without valid
        vecs[3]  = '{1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b1}; // back-to-back 0
        vecs[4]  = '{1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b1}; // 1
        vecs[5]  = '{1'b1, 1'b0, 2'd2, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b1}; // 2
        vecs[6]  = '{1'b1, 1'b0, 2'd3, 1'b1, 1'b1, 4'b1000, 2'd3, 1'b1}; // 3
        vecs[7]  = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0}; // en drop wins
        vecs[8]  = '{1'b1, 1'b0, 2'd2, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0}; // re-enter DIRECT
        vecs[9]  = '{1'b1, 1'b0, 2'd2, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b1}; // capture 2
        vecs[10] = '{1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 4'b0001, 2'd0, 1'b1}; // enter SCAN, sel ignored
        vecs[11] = '{1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 4'b0001, 2'd0, 1'b1}; // dwell
        vecs[12] = '{1'b1, 1'b0, 2'd3, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0}; // abort scan mid-dwell
        vecs[13] = '{1'b1, 1'b0, 2'd3, 1'b1, 1'b1, 4'b1000, 2'd3, 1'b1}; // capture 3

        rst = 1'b1; en = 1'b0; mode = 1'b0; sel = '0; in_valid = 1'b0;
        en2 = 1'b0; mode2 = 1'b0; sel2 = '0; in_valid2 = 1'b0;
        #12;
        chk_out("reset", 0, 0, 0, 0);
        chk("reset.in_ready", 32'(in_ready), 0);
        rst = 1'b0;
        step();
        chk_out("idle", 0, 0, 0, 0);

        // Direct-mode vector table
        for (int i = 0; i < 14; i++) begin
            en = vecs[i].en; mode = vecs[i].mode; sel = vecs[i].sel; in_valid = vecs[i].iv;
            #1;
            chk($sformatf("v%0d.in_ready", i), 32'(in_ready), 32'(vecs[i].rdy));
            step();
            chk_out($sformatf("v%0d", i), 32'(vecs[i].dout), 32'(vecs[i].idx), 32'(vecs[i].ov), 0);
        end
        in_valid = 1'b0;

        // 20-cycle scan from DIRECT: four dwell periods then wrap
        en = 1'b1; mode = 1'b1; sel = 2'd2; in_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            e_idx = 32'((c / 4) % 4);
            chk_out($sformatf("scan%0d", c), 32'(1) << e_idx, e_idx, 1, (c == 16) ? 1 : 0);
            chk($sformatf("scan%0d.in_ready", c), 32'(in_ready), 0);
        end
        in_valid = 1'b0;

        // Async reset mid-scan at idx=2
        en = 1'b0;
        step();
        chk_out("idle2", 0, 0, 0, 0);
        en = 1'b1; mode = 1'b1;
        for (int c = 0; c < 9; c++) step();
        chk_out("prerst", 4'b0100, 2, 1, 0);
        rst = 1'b1;
        mode = 1'b0;
        #2;
        chk_out("asyncrst", 0, 0, 0, 0);
        chk("asyncrst.in_ready", 32'(in_ready), 0);
        mode = 1'b1;
        #1;
        rst = 1'b0;
        step();
        chk_out("restart0", 4'b0001, 0, 1, 0);
        step(); step(); step();
        chk_out("restart3", 4'b0001, 0, 1, 0);
        step();
        chk_out("restart4", 4'b0010, 1, 1, 0);

        // N=3, DWELL=1: rotate every cycle, wrap every 8
        en2 = 1'b1; mode2 = 1'b1;
        wraps = 0;
        for (int c = 0; c < 17; c++) begin
            step();
            e_idx = 32'(c % 8);
            chk($sformatf("d1_%0d.dout", c), 32'(dout2), 32'(1) << e_idx);
            chk($sformatf("d1_%0d.idx", c), 32'(idx2), e_idx);
            chk($sformatf("d1_%0d.wrap", c), 32'(wrap2), (c > 0 && c % 8 == 0) ? 1 : 0);
            if (wrap2) wraps++;
        end
        chk("d1.wrap_count", 32'(wraps), 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
